// File: rtl/openhw_ahb_pkg.sv
// Shared definitions for the AHB-Lite subordinate front end:
// HTRANS/HRESP encodings, the control state enum and the transfer legality check.
package openhw_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2,
        ST_POSTED
    } ahb_state_e;

    // True for the two HTRANS codes that carry a real transfer.
    function automatic logic htrans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

    // Size must fit the bus and the address must be aligned to the size.
    function automatic logic xfer_legal(input logic [2:0] size,
                                        input logic [2:0] addr_lo,
                                        input logic [2:0] max_size);
        logic [2:0] amask;
        if (size > max_size) begin
            return 1'b0;
        end
        amask = (size >= 3'd3) ? 3'b111 : 3'((4'd1 << size) - 4'd1);
        return (addr_lo & amask) == 3'b000;
    endfunction

endpackage

// File: rtl/openhw_ahb_bytemask.sv
// Byte-lane enable generator: lanes [lo, lo + 2^size - 1] of an NB-lane bus.
module openhw_ahb_bytemask #(
    parameter int unsigned NB = 8,
    parameter int unsigned LB = 3
) (
    input  logic [2:0]    size,
    input  logic [LB-1:0] lo,
    output logic [NB-1:0] be
);

    // Mark every lane that falls inside the addressed byte window.
    always_comb begin : mask_calc
        int unsigned base;
        int unsigned span;
        base = 32'(lo);
        span = 32'd1 << size;
        be   = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            be[i] = (i >= base) && (i < base + span);
        end
    end

endmodule

// File: rtl/openhw_ahb_subordinate.sv
// AHB-Lite subordinate front end: turns each bus transfer into one back-end
// req/ack, with two-cycle ERROR responses for illegal transfers, back-end
// errors and back-end timeouts.
// Optional feature: OPENHW_AHBSUB_POSTED_WRITE_EN enables a one-entry posted
// write buffer (writes complete on the bus before the back end acks).
module openhw_ahb_subordinate
    import openhw_ahb_pkg::*;
#(
    parameter int unsigned PA_BITS        = 32,
    parameter int unsigned AHBW           = 64,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 HSEL,
    input  logic [1:0]           HTRANS,
    input  logic                 HWRITE,
    input  logic [2:0]           HSIZE,
    input  logic [PA_BITS-1:0]   HADDR,
    input  logic [AHBW-1:0]      HWDATA,
    input  logic                 HREADY,
    output logic                 HREADYOUT,
    output logic                 HRESP,
    output logic [AHBW-1:0]      HRDATA,
    output logic                 MemReq,
    output logic                 MemWrite,
    output logic [PA_BITS-1:0]   MemAddr,
    output logic [AHBW/8-1:0]    MemByteEn,
    output logic [AHBW-1:0]      MemWData,
    input  logic                 MemAck,
    input  logic                 MemErr,
    input  logic [AHBW-1:0]      MemRData,
    output logic                 PostedErr
);

    localparam int unsigned NB       = AHBW / 8;
    localparam int unsigned LB       = $clog2(NB);
    localparam logic [2:0]  MAX_SIZE = 3'(LB);
    localparam int unsigned CW       = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
`ifdef OPENHW_AHBSUB_POSTED_WRITE_EN
    localparam logic POSTED_EN = 1'b1;
`else
    localparam logic POSTED_EN = 1'b0;
`endif

    ahb_state_e          state_q, state_d, tgt_fresh;
    logic                a_write;
    logic [2:0]          a_size;
    logic [PA_BITS-1:0]  a_addr;
    logic [CW-1:0]       cnt_q;
    logic [NB-1:0]       be_a;
    logic                accept_ok, accept, fresh_legal, expired, pend_ok;
    logic                hreadyout, hresp, mem_req, cnt_clr;

    assign fresh_legal = xfer_legal(HSIZE, HADDR[2:0], MAX_SIZE);
    assign accept_ok   = (state_q == ST_IDLE) || (state_q == ST_ERR2) ||
                         ((state_q == ST_ACCESS) && MemAck && !MemErr) || pend_ok;
    assign accept      = accept_ok && HSEL && HREADY && htrans_active(HTRANS);
    assign tgt_fresh   = !fresh_legal ? ST_ERR1 :
                         (POSTED_EN && HWRITE) ? ST_POSTED : ST_ACCESS;
    // The timeout fires in the last allowed wait cycle so MemReq is high for
    // exactly TIMEOUT_CYCLES cycles before the error pair.
    assign expired     = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST) && !MemAck;

`ifdef OPENHW_AHBSUB_POSTED_WRITE_EN
    logic                pend_q, pend_set, pend_clr, p_from_pend;
    logic                post_err_d, post_err_q, a_legal, p_first;
    logic [2:0]          p_size;
    logic [PA_BITS-1:0]  p_addr;
    logic [AHBW-1:0]     p_data;
    logic [NB-1:0]       be_p;
    ahb_state_e          tgt_pend;

    assign pend_ok  = (state_q == ST_POSTED) && !pend_q;
    assign tgt_pend = !a_legal ? ST_ERR1 : (a_write ? ST_POSTED : ST_ACCESS);
`else
    assign pend_ok  = 1'b0;
`endif

    // Next-state and bus/back-end handshake decode.
    always_comb begin
        state_d   = state_q;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        mem_req   = 1'b0;
        cnt_clr   = 1'b0;
`ifdef OPENHW_AHBSUB_POSTED_WRITE_EN
        pend_set    = 1'b0;
        pend_clr    = 1'b0;
        p_from_pend = 1'b0;
        post_err_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (state_q == ST_ERR2) hresp = HRESP_ERROR;
                if (accept) begin
                    state_d = tgt_fresh;
                    cnt_clr = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                mem_req   = 1'b1;
                hreadyout = MemAck && !MemErr;
                if (MemAck) begin
                    if (MemErr) begin
                        state_d = ST_ERR1;
                    end else if (accept) begin
                        state_d = tgt_fresh;
                        cnt_clr = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (expired) begin
                    state_d = ST_ERR1;
                end
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
                state_d   = ST_ERR2;
            end
`ifdef OPENHW_AHBSUB_POSTED_WRITE_EN
            // A transfer accepted while the buffer is busy is parked in the
            // address registers and dispatched once the buffer drains.
            ST_POSTED: begin
                mem_req   = 1'b1;
                hreadyout = !pend_q;
                if (MemAck || expired) begin
                    post_err_d = MemAck ? MemErr : 1'b1;
                    if (pend_q) begin
                        state_d     = tgt_pend;
                        cnt_clr     = 1'b1;
                        pend_clr    = 1'b1;
                        p_from_pend = 1'b1;
                    end else if (accept) begin
                        state_d = tgt_fresh;
                        cnt_clr = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (accept) begin
                    pend_set = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Address-phase capture on every accepted transfer.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            a_write <= 1'b0;
            a_size  <= '0;
            a_addr  <= '0;
        end else if (accept) begin
            a_write <= HWRITE;
            a_size  <= HSIZE;
            a_addr  <= HADDR;
        end
    end

    // Back-end wait counter: cleared on dispatch, saturating while unacked.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)                                  cnt_q <= '0;
        else if (cnt_clr)                            cnt_q <= '0;
        else if (mem_req && !MemAck && cnt_q != '1)  cnt_q <= cnt_q + 1'b1;
    end

    openhw_ahb_bytemask #(.NB(NB), .LB(LB)) u_be_a (
        .size (a_size),
        .lo   (a_addr[LB-1:0]),
        .be   (be_a)
    );

`ifdef OPENHW_AHBSUB_POSTED_WRITE_EN
    // Posted-write buffer: address loads on dispatch, data in its first cycle.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            pend_q     <= 1'b0;
            post_err_q <= 1'b0;
            a_legal    <= 1'b0;
            p_first    <= 1'b0;
            p_size     <= '0;
            p_addr     <= '0;
            p_data     <= '0;
        end else begin
            post_err_q <= post_err_d;
            if (accept)        a_legal <= fresh_legal;
            if (pend_set)      pend_q  <= 1'b1;
            else if (pend_clr) pend_q  <= 1'b0;
            if (cnt_clr && state_d == ST_POSTED) begin
                p_first <= 1'b1;
                p_size  <= p_from_pend ? a_size : HSIZE;
                p_addr  <= p_from_pend ? a_addr : HADDR;
            end else if (p_first) begin
                p_first <= 1'b0;
                p_data  <= HWDATA;
            end
        end
    end

    openhw_ahb_bytemask #(.NB(NB), .LB(LB)) u_be_p (
        .size (p_size),
        .lo   (p_addr[LB-1:0]),
        .be   (be_p)
    );

    assign MemWrite  = (state_q == ST_POSTED) ? 1'b1 : a_write;
    assign MemAddr   = (state_q == ST_POSTED) ? {p_addr[PA_BITS-1:LB], {LB{1'b0}}}
                                              : {a_addr[PA_BITS-1:LB], {LB{1'b0}}};
    assign MemByteEn = (state_q == ST_POSTED) ? be_p : be_a;
    assign MemWData  = (state_q == ST_POSTED && !p_first) ? p_data : HWDATA;
    assign PostedErr = post_err_q;
`else
    assign MemWrite  = a_write;
    assign MemAddr   = {a_addr[PA_BITS-1:LB], {LB{1'b0}}};
    assign MemByteEn = be_a;
    assign MemWData  = HWDATA;
    assign PostedErr = 1'b0;
`endif

    assign HREADYOUT = hreadyout;
    assign HRESP     = hresp;
    assign MemReq    = mem_req;
    assign HRDATA    = (state_q == ST_ACCESS && !a_write && MemAck) ? MemRData : '0;

endmodule

// File: tb/tb_openhw_ahb_subordinate.sv
// Directed self-checking bench for openhw_ahb_subordinate (AHBW=64,
// TIMEOUT_CYCLES=4). The posted-write scenario runs only when
// OPENHW_AHBSUB_POSTED_WRITE_EN is defined.
module tb_openhw_ahb_subordinate;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        HSEL = 1'b0;
    logic [1:0]  HTRANS = 2'b00;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = 3'd0;
    logic [31:0] HADDR = '0;
    logic [63:0] HWDATA = '0;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [63:0] HRDATA;
    logic        MemReq;
    logic        MemWrite;
    logic [31:0] MemAddr;
    logic [7:0]  MemByteEn;
    logic [63:0] MemWData;
    logic        MemAck = 1'b0;
    logic        MemErr = 1'b0;
    logic [63:0] MemRData = '0;
    logic        PostedErr;

    int ncmp = 0;
    int nfail = 0;

    always #5 HCLK = ~HCLK;

    // Single subordinate on the bus: its ready is the bus ready.
    assign HREADY = HREADYOUT;

    openhw_ahb_subordinate #(
        .PA_BITS        (32),
        .AHBW           (64),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .MemReq    (MemReq),
        .MemWrite  (MemWrite),
        .MemAddr   (MemAddr),
        .MemByteEn (MemByteEn),
        .MemWData  (MemWData),
        .MemAck    (MemAck),
        .MemErr    (MemErr),
        .MemRData  (MemRData),
        .PostedErr (PostedErr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic mid();
        @(negedge HCLK);
    endtask

    task automatic addr(input logic wr, input logic [2:0] sz, input logic [31:0] a);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = wr;
        HSIZE  = sz;
        HADDR  = a;
    endtask

    task automatic bus_idle();
        HTRANS = 2'b00;
    endtask

    initial begin
        // Reset values
        mid();
        chk("rst_hreadyout", 64'(HREADYOUT), 64'd1);
        chk("rst_hresp",     64'(HRESP),     64'd0);
        chk("rst_hrdata",    HRDATA,         64'd0);
        chk("rst_memreq",    64'(MemReq),    64'd0);
        chk("rst_postederr", 64'(PostedErr), 64'd0);
        step();
        HRESET = 1'b0;

        // BUSY and unselected transfers are ignored
        HSEL = 1'b1; HTRANS = 2'b01; HADDR = 32'h1000;
        step();
        mid();
        chk("busy_memreq",    64'(MemReq),    64'd0);
        chk("busy_hreadyout", 64'(HREADYOUT), 64'd1);
        HSEL = 1'b0; HTRANS = 2'b10;
        step();
        mid();
        chk("nosel_memreq", 64'(MemReq), 64'd0);

        // 1: 64-bit read acked in its first data cycle
        addr(1'b0, 3'd3, 32'h1000);
        step();
        bus_idle();
        MemAck = 1'b1; MemRData = 64'h0123_4567_89AB_CDEF;
        mid();
        chk("t1_memreq",    64'(MemReq),    64'd1);
        chk("t1_memwrite",  64'(MemWrite),  64'd0);
        chk("t1_memaddr",   64'(MemAddr),   64'h1000);
        chk("t1_byteen",    64'(MemByteEn), 64'hFF);
        chk("t1_hrdata",    HRDATA,         64'h0123_4567_89AB_CDEF);
        chk("t1_hreadyout", 64'(HREADYOUT), 64'd1);
        chk("t1_hresp",     64'(HRESP),     64'd0);
        step();
        MemAck = 1'b0;
        mid();
        chk("t1_idle_memreq", 64'(MemReq), 64'd0);
        chk("t1_idle_hrdata", HRDATA,      64'd0);

        // Halfword read at 0x1006: upper two lanes, aligned back-end address
        addr(1'b0, 3'd1, 32'h1006);
        step();
        bus_idle();
        MemAck = 1'b1; MemRData = 64'h0000_0000_0000_BEEF;
        mid();
        chk("hw_byteen",  64'(MemByteEn), 64'hC0);
        chk("hw_memaddr", 64'(MemAddr),   64'h1000);
        chk("hw_hrdata",  HRDATA,         64'h0000_0000_0000_BEEF);
        step();
        MemAck = 1'b0;

`ifndef OPENHW_AHBSUB_POSTED_WRITE_EN
        // 2: byte write to 0x1003, three wait states
        addr(1'b1, 3'd0, 32'h1003);
        step();
        bus_idle();
        HWDATA = 64'h0000_0000_AA00_0000;
        mid();
        chk("t2_byteen",   64'(MemByteEn), 64'h08);
        chk("t2_memwrite", 64'(MemWrite),  64'd1);
        chk("t2_wdata",    MemWData,       64'h0000_0000_AA00_0000);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) mid();
            chk($sformatf("t2_wait%0d_hreadyout", i), 64'(HREADYOUT), 64'd0);
            chk($sformatf("t2_wait%0d_memreq", i),    64'(MemReq),    64'd1);
            step();
        end
        MemAck = 1'b1;
        mid();
        chk("t2_done_hreadyout", 64'(HREADYOUT), 64'd1);
        chk("t2_done_hresp",     64'(HRESP),     64'd0);
        step();
        MemAck = 1'b0;
`endif

        // 3: misaligned word -> error pair, no back-end request
        addr(1'b0, 3'd2, 32'h1002);
        step();
        bus_idle();
        mid();
        chk("t3_err1_hreadyout", 64'(HREADYOUT), 64'd0);
        chk("t3_err1_hresp",     64'(HRESP),     64'd1);
        chk("t3_err1_memreq",    64'(MemReq),    64'd0);
        step();
        mid();
        chk("t3_err2_hreadyout", 64'(HREADYOUT), 64'd1);
        chk("t3_err2_hresp",     64'(HRESP),     64'd1);
        chk("t3_err2_memreq",    64'(MemReq),    64'd0);
        step();
        mid();
        chk("t3_after_hresp", 64'(HRESP), 64'd0);

        // Oversized transfer (16 bytes on a 64-bit bus) is illegal
        addr(1'b0, 3'd4, 32'h1000);
        step();
        bus_idle();
        mid();
        chk("big_hresp",     64'(HRESP),     64'd1);
        chk("big_hreadyout", 64'(HREADYOUT), 64'd0);
        step();
        step();

        // 4: back end never acks, timeout after 4 request cycles
        addr(1'b0, 3'd3, 32'h2000);
        step();
        bus_idle();
        for (int i = 0; i < 4; i++) begin
            mid();
            chk($sformatf("t4_req%0d_memreq", i),    64'(MemReq),    64'd1);
            chk($sformatf("t4_req%0d_hreadyout", i), 64'(HREADYOUT), 64'd0);
            step();
        end
        mid();
        chk("t4_err1_memreq",    64'(MemReq),    64'd0);
        chk("t4_err1_hreadyout", 64'(HREADYOUT), 64'd0);
        chk("t4_err1_hresp",     64'(HRESP),     64'd1);
        step();
        mid();
        chk("t4_err2_hreadyout", 64'(HREADYOUT), 64'd1);
        chk("t4_err2_hresp",     64'(HRESP),     64'd1);
        step();

        // Back-end error: OKAY-less wait cycle, then the error pair
        addr(1'b0, 3'd3, 32'h2008);
        step();
        bus_idle();
        MemAck = 1'b1; MemErr = 1'b1;
        mid();
        chk("me_hreadyout", 64'(HREADYOUT), 64'd0);
        chk("me_hresp",     64'(HRESP),     64'd0);
        step();
        MemAck = 1'b0; MemErr = 1'b0;
        mid();
        chk("me_err1_hreadyout", 64'(HREADYOUT), 64'd0);
        chk("me_err1_hresp",     64'(HRESP),     64'd1);
        step();
        mid();
        chk("me_err2_hreadyout", 64'(HREADYOUT), 64'd1);
        chk("me_err2_hresp",     64'(HRESP),     64'd1);
        step();

        // 5: back-to-back read 0x0 then write 0x8, both acked immediately
        addr(1'b0, 3'd3, 32'h0);
        step();
        addr(1'b1, 3'd3, 32'h8);
        MemAck = 1'b1; MemRData = 64'hFEED_FACE_CAFE_F00D;
        mid();
        chk("t5_rd_hreadyout", 64'(HREADYOUT), 64'd1);
        chk("t5_rd_hrdata",    HRDATA,         64'hFEED_FACE_CAFE_F00D);
        chk("t5_rd_memaddr",   64'(MemAddr),   64'h0);
        step();
        bus_idle();
        HWDATA = 64'h1111_2222_3333_4444;
        mid();
        chk("t5_wr_hreadyout", 64'(HREADYOUT), 64'd1);
        chk("t5_wr_hresp",     64'(HRESP),     64'd0);
        chk("t5_wr_memwrite",  64'(MemWrite),  64'd1);
        chk("t5_wr_memaddr",   64'(MemAddr),   64'h8);
        chk("t5_wr_wdata",     MemWData,       64'h1111_2222_3333_4444);
        step();
        MemAck = 1'b0;
        mid();
        chk("t5_end_memreq", 64'(MemReq), 64'd0);

        // 6: asynchronous reset in the middle of an access
        addr(1'b0, 3'd3, 32'h3000);
        step();
        bus_idle();
        mid();
        chk("t6_pre_memreq", 64'(MemReq), 64'd1);
        #2 HRESET = 1'b1;
        #1;
        chk("t6_rst_memreq",    64'(MemReq),    64'd0);
        chk("t6_rst_hreadyout", 64'(HREADYOUT), 64'd1);
        chk("t6_rst_hresp",     64'(HRESP),     64'd0);
        step();
        HRESET = 1'b0;
        mid();
        chk("t6_after_memreq", 64'(MemReq), 64'd0);

`ifdef OPENHW_AHBSUB_POSTED_WRITE_EN
        // Posted write failing in the back end while a read waits behind it
        addr(1'b1, 3'd3, 32'h4000);
        step();
        addr(1'b0, 3'd3, 32'h5000);
        HWDATA = 64'h5555_6666_7777_8888;
        mid();
        chk("pw_hreadyout", 64'(HREADYOUT), 64'd1);
        chk("pw_memreq",    64'(MemReq),    64'd1);
        chk("pw_memwrite",  64'(MemWrite),  64'd1);
        chk("pw_memaddr",   64'(MemAddr),   64'h4000);
        chk("pw_wdata",     MemWData,       64'h5555_6666_7777_8888);
        step();
        bus_idle();
        HWDATA = 64'hDEAD_DEAD_DEAD_DEAD;
        MemAck = 1'b1; MemErr = 1'b1;
        mid();
        chk("pw_stall_hreadyout", 64'(HREADYOUT), 64'd0);
        chk("pw_stall_wdata",     MemWData,       64'h5555_6666_7777_8888);
        chk("pw_stall_hresp",     64'(HRESP),     64'd0);
        step();
        MemAck = 1'b0; MemErr = 1'b0;
        mid();
        chk("pw_postederr",   64'(PostedErr), 64'd1);
        chk("pw_rd_memwrite", 64'(MemWrite),  64'd0);
        chk("pw_rd_memaddr",  64'(MemAddr),   64'h5000);
        chk("pw_rd_hreadyout", 64'(HREADYOUT), 64'd0);
        step();
        MemAck = 1'b1; MemRData = 64'h0A0B_0C0D_0E0F_1011;
        mid();
        chk("pw_rd_done_hreadyout", 64'(HREADYOUT), 64'd1);
        chk("pw_rd_hrdata",         HRDATA,         64'h0A0B_0C0D_0E0F_1011);
        chk("pw_postederr_pulse",   64'(PostedErr), 64'd0);
        step();
        MemAck = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
